// File: rtl/fetch_unit_if.sv
// ---------------------------------------------------------------------------
// fetch_unit_if
//
// Bundles the next-PC control inputs and the fetch results exchanged
// between the fetch stage and its neighbours (decode / register file).
//
// Signals:
//   pc_src        3   next-PC select (000 seq, 001 branch, 010 jump,
//                     011 jr, 100 jalpc, others seq)
//   branch_offset 32  sign-extended imm16, in words
//   jump_index    26  instr[25:0]
//   jr_target     32  register value for JR/JALR
//   stall         1   hold the PC for this edge
//   halt          1   SYSCALL seen, stop after this instruction
//   instr         32  instruction word at pc
//   pc            32  current PC
//   pc_plus4      32  pc + 4, link value
//   halted        1   core stopped
//   misaligned    1   sticky misaligned-target flag
//   fetch_count   32  PC advances since reset
//
// Modports:
//   master : the side that steers fetch (decode/control, or a bench)
//   slave  : the fetch unit itself
// ---------------------------------------------------------------------------
interface fetch_unit_if;
    logic [2:0]  pc_src;
    logic [31:0] branch_offset;
    logic [25:0] jump_index;
    logic [31:0] jr_target;
    logic        stall;
    logic        halt;
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        halted;
    logic        misaligned;
    logic [31:0] fetch_count;

    modport master (
        output pc_src, branch_offset, jump_index, jr_target, stall, halt,
        input  instr, pc, pc_plus4, halted, misaligned, fetch_count
    );

    modport slave (
        input  pc_src, branch_offset, jump_index, jr_target, stall, halt,
        output instr, pc, pc_plus4, halted, misaligned, fetch_count
    );
endinterface

// File: rtl/fetch_unit.sv
// ---------------------------------------------------------------------------
// fetch_unit
//
// Instruction fetch stage of the single-cycle MIPS core. Holds the PC,
// reads the big-endian instruction word at the PC from an internal
// byte-addressed memory (combinational read, address wraps modulo
// IMEM_BYTES), selects the next PC, and owns the RUN/HALTED state, the
// sticky misaligned flag and the retired-fetch counter.
//
// Parameters:
//   RESET_PC    PC loaded on reset (word-aligned)
//   IMEM_BYTES  instruction memory size in bytes (power of two, >= 4)
//
// Ports:
//   clk    rising-edge clock
//   reset  synchronous, active-high reset
//   bus    fetch_unit_if.slave (control inputs and fetch outputs)
//
// Build option:
//   FETCH_JALPC_EN  when defined, pc_src=100 selects the PC-relative
//                   jalpc target; otherwise 100 behaves as sequential.
//
// The memory array `bytes` has no write port; it is preloaded through
// hierarchy by the simulation environment.
// ---------------------------------------------------------------------------
module fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          IMEM_BYTES = 1024
) (
    input  logic         clk,
    input  logic         reset,
    fetch_unit_if.slave  bus
);
    localparam int AW = $clog2(IMEM_BYTES);

    typedef enum logic {
        RUN    = 1'b0,
        HALTED = 1'b1
    } state_t;

    logic [7:0]  bytes [0:IMEM_BYTES-1];

    state_t      state_reg;
    state_t      state_next;
    logic [31:0] pc_reg;
    logic [31:0] count_reg;
    logic        misaligned_reg;

    logic [31:0] pc_plus4;
    logic [31:0] target;
    logic        target_aligned;
    logic        advance;
    logic        set_misaligned;

    logic [AW-1:0] base_addr;
    logic [7:0]    instr_bytes [0:3];

    assign pc_plus4  = pc_reg + 32'd4;
    assign base_addr = pc_reg[AW-1:0];

    // One byte lane per instruction byte; lane 0 is the most significant.
    // Lane addresses are AW bits wide so they wrap around the memory.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            logic [AW-1:0] lane_addr;
            assign lane_addr       = base_addr + AW'(gi);
            assign instr_bytes[gi] = bytes[lane_addr];
        end
    endgenerate

    assign bus.instr = {instr_bytes[0], instr_bytes[1], instr_bytes[2], instr_bytes[3]};

    // Next-PC selection; all sums wrap modulo 2^32.
    always_comb begin
        target = pc_plus4;
        case (bus.pc_src)
            3'b001:  target = pc_plus4 + (bus.branch_offset << 2);
            3'b010:  target = {pc_plus4[31:28], bus.jump_index, 2'b00};
            3'b011:  target = bus.jr_target;
`ifdef FETCH_JALPC_EN
            3'b100:  target = pc_plus4 + {{4{bus.jump_index[25]}}, bus.jump_index, 2'b00};
`endif
            default: target = pc_plus4;
        endcase
    end

    assign target_aligned = (target[1:0] == 2'b00);

    // State register plus the datapath registers it governs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg      <= RUN;
            pc_reg         <= RESET_PC;
            count_reg      <= 32'd0;
            misaligned_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (advance) begin
                pc_reg    <= target;
                count_reg <= count_reg + 32'd1;
            end
            if (set_misaligned) begin
                misaligned_reg <= 1'b1;
            end
        end
    end

    // Next state: stall beats halt, halt beats a misaligned target.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            RUN: begin
                if (!bus.stall && (bus.halt || !target_aligned)) begin
                    state_next = HALTED;
                end
            end
            HALTED:  state_next = HALTED;
            default: state_next = RUN;
        endcase
    end

    // Outputs and register enables decoded from the current state.
    always_comb begin
        advance        = 1'b0;
        set_misaligned = 1'b0;
        bus.halted     = 1'b0;
        case (state_reg)
            RUN: begin
                if (!bus.stall && !bus.halt) begin
                    if (target_aligned) begin
                        advance = 1'b1;
                    end else begin
                        set_misaligned = 1'b1;
                    end
                end
            end
            HALTED:  bus.halted = 1'b1;
            default: bus.halted = 1'b0;
        endcase
    end

    assign bus.pc          = pc_reg;
    assign bus.pc_plus4    = pc_plus4;
    assign bus.misaligned  = misaligned_reg;
    assign bus.fetch_count = count_reg;
endmodule

// File: tb/tb_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_fetch_unit
//
// Self-checking bench for fetch_unit: a table of directed vectors from the
// test plan, a hand-written jalpc sequence, then randomized cycles compared
// against a behavioural model of the fetch rules.
// ---------------------------------------------------------------------------
module tb_fetch_unit;
    localparam int IMEM_BYTES = 1024;
    localparam int N_RANDOM   = 1500;

    logic clk;
    logic reset;

    fetch_unit_if bus ();

    fetch_unit #(
        .RESET_PC   (32'h0000_0000),
        .IMEM_BYTES (IMEM_BYTES)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic [2:0]  src;
        logic [31:0] boff;
        logic [25:0] ji;
        logic [31:0] jrt;
        logic        stall;
        logic        halt;
        logic [31:0] e_pc;
        logic [31:0] e_cnt;
        logic        e_halted;
        logic        e_mis;
    } vec_t;

    vec_t       vecs[$];
    logic [7:0] mem_model [0:IMEM_BYTES-1];
    int         n_checks;
    int         n_fail;

    // Reference model state
    logic [31:0] m_pc;
    logic [31:0] m_cnt;
    logic        m_halted;
    logic        m_mis;

    function automatic logic [31:0] model_instr(input logic [31:0] p);
        logic [31:0] w;
        w = 32'd0;
        for (int k = 0; k < 4; k++) begin
            w = (w << 8) | 32'(mem_model[(int'(p % IMEM_BYTES) + k) % IMEM_BYTES]);
        end
        return w;
    endfunction

    function automatic logic [31:0] model_target(input logic [31:0] p, input logic [2:0] s,
                                                 input logic [31:0] bo, input logic [25:0] ji,
                                                 input logic [31:0] jt);
        logic [31:0] seqv;
        longint      off;
        seqv = p + 32'd4;
        off  = 0;
        case (s)
            3'd1: return seqv + bo * 32'd4;
            3'd2: return (seqv & 32'hF000_0000) + 32'(ji) * 32'd4;
            3'd3: return jt;
`ifdef FETCH_JALPC_EN
            3'd4: begin
                off = longint'(ji) * 4;
                if (off >= 64'sd134217728) off = off - 64'sd268435456;
                return seqv + 32'(off);
            end
`endif
            default: return seqv;
        endcase
    endfunction

    task automatic model_step(input logic r, input logic [2:0] s, input logic [31:0] bo,
                              input logic [25:0] ji, input logic [31:0] jt,
                              input logic st, input logic h);
        logic [31:0] n;
        if (r) begin
            m_pc = 32'd0; m_cnt = 32'd0; m_halted = 1'b0; m_mis = 1'b0;
        end else if (m_halted || st) begin
            // frozen or stalled
        end else if (h) begin
            m_halted = 1'b1;
        end else begin
            n = model_target(m_pc, s, bo, ji, jt);
            if (n % 4 != 0) begin
                m_mis = 1'b1; m_halted = 1'b1;
            end else begin
                m_pc = n; m_cnt = m_cnt + 32'd1;
            end
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic [2:0] s, input logic [31:0] bo,
                         input logic [25:0] ji, input logic [31:0] jt,
                         input logic st, input logic h);
        reset             = r;
        bus.pc_src        = s;
        bus.branch_offset = bo;
        bus.jump_index    = ji;
        bus.jr_target     = jt;
        bus.stall         = st;
        bus.halt          = h;
        @(posedge clk);
        #1;
    endtask

    task automatic check_all(input string tag, input logic [31:0] e_pc, input logic [31:0] e_cnt,
                             input logic e_h, input logic e_m);
        chk({tag, ".pc"},          bus.pc,          e_pc);
        chk({tag, ".pc_plus4"},    bus.pc_plus4,    e_pc + 32'd4);
        chk({tag, ".instr"},       bus.instr,       model_instr(e_pc));
        chk({tag, ".fetch_count"}, bus.fetch_count, e_cnt);
        chk({tag, ".halted"},      32'(bus.halted),     32'(e_h));
        chk({tag, ".misaligned"},  32'(bus.misaligned), 32'(e_m));
    endtask

    task automatic add(input logic r, input logic [2:0] s, input logic [31:0] bo,
                       input logic [25:0] ji, input logic [31:0] jt, input logic st,
                       input logic h, input logic [31:0] pc_e, input logic [31:0] cnt_e,
                       input logic h_e, input logic m_e);
        vec_t v;
        v.rst = r; v.src = s; v.boff = bo; v.ji = ji; v.jrt = jt; v.stall = st; v.halt = h;
        v.e_pc = pc_e; v.e_cnt = cnt_e; v.e_halted = h_e; v.e_mis = m_e;
        vecs.push_back(v);
    endtask

    logic        r_r, r_st, r_h;
    logic [2:0]  r_s;
    logic [31:0] r_bo, r_jt;
    logic [25:0] r_ji;
    logic [31:0] jal_pc;

    initial begin
        n_checks = 0;
        n_fail   = 0;
        for (int i = 0; i < IMEM_BYTES; i++) begin
            mem_model[i] = 8'($urandom);
            dut.bytes[i] = mem_model[i];
        end

        // rst src boff ji jrt stall halt | pc cnt halted mis
        add(1, 3'd0, 0, 0, 0, 0, 0,              32'h00, 0, 0, 0);
        add(0, 3'd0, 0, 0, 0, 0, 0,              32'h04, 1, 0, 0);
        add(0, 3'd0, 0, 0, 0, 0, 0,              32'h08, 2, 0, 0);
        add(0, 3'd0, 0, 0, 0, 0, 0,              32'h0C, 3, 0, 0);
        add(0, 3'd0, 0, 0, 0, 0, 0,              32'h10, 4, 0, 0);
        add(0, 3'd1, 32'hFFFF_FFFE, 0, 0, 0, 0,  32'h0C, 5, 0, 0);
        add(1, 3'd2, 0, 26'h40, 0, 0, 1,         32'h00, 0, 0, 0);
        add(0, 3'd0, 0, 0, 0, 0, 0,              32'h04, 1, 0, 0);
        add(0, 3'd7, 0, 0, 0, 0, 0,              32'h08, 2, 0, 0);
        add(0, 3'd2, 0, 26'h40, 0, 1, 1,         32'h08, 2, 0, 0);
        add(0, 3'd3, 0, 0, 32'h42, 1, 1,         32'h08, 2, 0, 0);
        add(0, 3'd2, 0, 26'h08, 0, 0, 0,         32'h20, 3, 0, 0);
        add(0, 3'd2, 0, 26'h40, 0, 0, 0,         32'h100, 4, 0, 0);
        add(0, 3'd3, 0, 0, 32'h14, 0, 0,         32'h14, 5, 0, 0);
        add(0, 3'd2, 0, 26'h40, 0, 0, 1,         32'h14, 5, 1, 0);
        add(0, 3'd2, 0, 26'h40, 0, 0, 0,         32'h14, 5, 1, 0);
        add(0, 3'd0, 0, 0, 0, 0, 0,              32'h14, 5, 1, 0);
        add(0, 3'd3, 0, 0, 32'h43, 0, 0,         32'h14, 5, 1, 0);
        add(0, 3'd1, 32'h10, 0, 0, 1, 1,         32'h14, 5, 1, 0);
        add(0, 3'd3, 0, 0, 32'h80, 0, 0,         32'h14, 5, 1, 0);
        add(1, 3'd3, 0, 0, 32'h43, 0, 1,         32'h00, 0, 0, 0);
        add(0, 3'd3, 0, 0, 32'h42, 0, 0,         32'h00, 0, 1, 1);
        add(0, 3'd1, 32'h4, 0, 0, 0, 0,          32'h00, 0, 1, 1);
        add(1, 3'd0, 0, 0, 0, 0, 0,              32'h00, 0, 0, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].rst, vecs[i].src, vecs[i].boff, vecs[i].ji, vecs[i].jrt,
                  vecs[i].stall, vecs[i].halt);
            check_all($sformatf("vec%0d", i), vecs[i].e_pc, vecs[i].e_cnt,
                      vecs[i].e_halted, vecs[i].e_mis);
            $display("vec %0d: rst=%0d src=%0d stall=%0d halt=%0d -> pc=%08h cnt=%0d halted=%0d mis=%0d",
                     i, vecs[i].rst, vecs[i].src, vecs[i].stall, vecs[i].halt,
                     bus.pc, bus.fetch_count, bus.halted, bus.misaligned);
        end

        // jalpc at pc=0x20 with offset -4: lands back on 0x20 when enabled,
        // otherwise behaves as sequential.
`ifdef FETCH_JALPC_EN
        jal_pc = 32'h20;
`else
        jal_pc = 32'h24;
`endif
        drive(0, 3'd2, 0, 26'h08, 0, 0, 0);
        check_all("jalpc_setup", 32'h20, 32'd1, 1'b0, 1'b0);
        drive(0, 3'd4, 0, 26'h3FF_FFFF, 0, 0, 0);
        check_all("jalpc", jal_pc, 32'd2, 1'b0, 1'b0);
        $display("jalpc: pc=%08h cnt=%0d", bus.pc, bus.fetch_count);

        // Randomized phase against the behavioural model
        m_pc = 32'd0; m_cnt = 32'd0; m_halted = 1'b0; m_mis = 1'b0;
        for (int i = 0; i < N_RANDOM; i++) begin
            r_r  = (i == 0) || ($urandom_range(0, 39) == 0);
            r_s  = 3'($urandom_range(0, 7));
            r_bo = 32'($signed($urandom_range(0, 64)) - 32);
            r_ji = 26'($urandom);
            r_jt = ($urandom_range(0, 15) == 0) ? 32'($urandom) : (32'($urandom) & 32'hFFFF_FFFC);
            r_st = ($urandom_range(0, 3) == 0);
            r_h  = ($urandom_range(0, 49) == 0);
            drive(r_r, r_s, r_bo, r_ji, r_jt, r_st, r_h);
            model_step(r_r, r_s, r_bo, r_ji, r_jt, r_st, r_h);
            check_all($sformatf("rnd%0d", i), m_pc, m_cnt, m_halted, m_mis);
            $display("rnd %0d: rst=%0d src=%0d stall=%0d halt=%0d -> pc=%08h cnt=%0d halted=%0d mis=%0d",
                     i, r_r, r_s, r_st, r_h, bus.pc, bus.fetch_count, bus.halted, bus.misaligned);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage of the single-cycle MIPS core: it holds the program counter, reads the current instruction word from its internal byte-addressed instruction memory, and computes the next PC from the control/decode selection. It sits directly upstream of decode and the register file. It supplies `instr`, `pc` and `pc_plus4`; `pc_plus4` is the link value for JAL/JALPC register writes. It also owns the run/halt state and the retired-fetch counter the test benches inspect.

## Interface
- `RESET_PC`, 32'h0000_0000: PC value loaded on reset; must be word-aligned.
- `IMEM_BYTES`, 1024: instruction memory size in bytes; power of two, ≥ 4.
- `clk`  in  1: the single clock, rising edge.
- `reset`  in  1: synchronous, active-high.
- `pc_src`  in  3: next-PC select. 000 seq, 001 branch, 010 jump, 011 jr, 100 jalpc; 101–111 are treated as seq.
- `branch_offset`  in  32: sign-extended imm16, in words.
- `jump_index`  in  26: instr[25:0] field.
- `jr_target`  in  32: register value for JR/JALR.
- `stall`  in  1: holds the PC for this edge.
- `halt`  in  1: decoder saw SYSCALL; stop after this instruction.
- `instr`  out  32: instruction word at `pc`.
- `pc`  out  32: current PC.
- `pc_plus4`  out  32: `pc`+4, used as the link value.
- `halted`  out  1: core stopped.
- `misaligned`  out  1: sticky; set when a fetch was taken to a non-word-aligned target.
- `fetch_count`  out  32: number of PC advances since reset.

## Operation
- The memory is a reg [7:0] array named `bytes[0:IMEM_BYTES-1]`. Benches load it with `$readmemb` via hierarchy; there is no write port.
- `instr` = {bytes[a], bytes[a+1], bytes[a+2], bytes[a+3]}, big-endian, where a = pc mod IMEM_BYTES. Reads are combinational from `pc`. Address bits above log2(IMEM_BYTES) are ignored, so reads wrap around the memory.
- Next-PC targets, all 32-bit, with carries discarded (wrap modulo 2^32):
  - seq: pc_plus4.
  - branch: pc_plus4 + (branch_offset << 2).
  - jump: {pc_plus4[31:28], jump_index, 2'b00}.
  - jr: jr_target.
  - jalpc: pc_plus4 + sign_extend({jump_index, 2'b00}) from 28 to 32 bits.
- States:
  - RUN (reset state):
    - Edge with stall=1: PC and count hold.
    - Edge with stall=0 and halt=1: go to HALTED. PC holds at the SYSCALL address; count holds.
    - Edge with stall=0, halt=0 and next[1:0]≠0: set misaligned and go to HALTED. PC holds.
    - Otherwise: pc ← next and fetch_count ← fetch_count+1.
  - HALTED: all inputs except reset are ignored. PC, count and flags are frozen; `halted`=1.
- Precedence: reset > stall > halt > misaligned > advance.

## Timing
- Reset values: pc=RESET_PC, halted=0, misaligned=0, fetch_count=0, state RUN. `instr` shows the word at RESET_PC in the first cycle after reset.
- Reset is sampled only on a rising edge. If it is asserted mid-run or while HALTED, the block returns to the reset values on that edge regardless of other inputs.
- Latency: the PC updates on the same edge that samples `pc_src`, so a jump or branch takes effect on the next cycle's `instr`. There are no delay slots.
- `halted` and `misaligned` are registered: they rise one edge after the triggering cycle.
- fetch_count wraps from 32'hFFFF_FFFF to 0.

## Configuration
- `FETCH_JALPC_EN`:
  - Defined: pc_src=100 computes the PC-relative jalpc target described above.
  - Undefined: 100 behaves exactly as seq. The jalpc adder and sign-extension logic are not synthesized.

## Test plan
- Reset, then 3 cycles of seq with stall=0 → pc=0x0C, fetch_count=3, instr=word stored at bytes[12..15].
- At pc=0x10, branch_offset=32'hFFFF_FFFE (−2) → pc=0x0C next cycle.
- At pc=0x20, jump_index=26'h40 → pc=0x100. With FETCH_JALPC_EN: at pc=0x20, pc_src=100, jump_index=26'h3FF_FFFF → pc=0x20, since pc_plus4=0x24 and the offset is −4.
- stall=1 for 2 cycles at pc=0x08 → pc=0x08 and fetch_count unchanged. On the same edges halt=1 is ignored.
- halt=1 at pc=0x14 → halted=1 and pc stays 0x14 for 5 further cycles. Then reset=1 for one edge → pc=0, halted=0, fetch_count=0.
- jr with jr_target=0x0000_0042 → misaligned=1, halted=1, pc unchanged.
